// File: rtl/rr_merge_pkg.sv
// Shared types and helpers for the two-level round-robin merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MAX_PICK / PICK_W : widest request vector rr_pick can search, and its index width
//   width_of()        : index width for a count, never less than 1
//   rr_pick()         : first set bit at or after a pointer, wrapping
package rr_merge_pkg;

  localparam int MAX_PICK = 32;
  localparam int PICK_W   = 5;

  // Index width for n items. A single item still gets one bit so that
  // group and select fields never collapse to zero width.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin search over the low n bits of vec (n a power of 2).
  // The search starts at ptr and wraps. The loop runs from the far end back
  // toward ptr, so the last hit written is the one closest to ptr.
  // Returns 0 when nothing is set; callers qualify the result with |vec.
  function automatic int rr_pick(input logic [MAX_PICK-1:0] vec,
                                 input int n,
                                 input int ptr);
    int idx;
    int k;
    idx = 0;
    for (int i = MAX_PICK - 1; i >= 0; i--) begin
      k = (ptr + i) & (n - 1);
      if ((i < n) && vec[k[PICK_W-1:0]]) begin
        idx = k;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_merge_mc_leaf.sv
// Leaf round-robin picker over RRWAYS request lines, with a rotating priority pointer.
// Latency: combinational pick and ready; the pointer updates on the accepting edge.
// Backpressure: ready goes to the picked way only when i_space is high, and never during reset.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   i_v        : per-way valid
//   i_space    : downstream stage is empty or is being popped this cycle
//   o_r        : one-hot ready to the picked way
//   o_acc      : a beat transfers on this edge
//   o_pick     : index of the picked way
module rr_arb_leaf
  import rr_merge_pkg::*;
#(
  parameter  int RRWAYS = 4,
  localparam int LEAF_W = $clog2(RRWAYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RRWAYS-1:0] i_v,
  input  logic              i_space,
  output logic [RRWAYS-1:0] o_r,
  output logic              o_acc,
  output logic [LEAF_W-1:0] o_pick
);

  logic [LEAF_W-1:0] r_ptr;
  logic              w_any;

  always_comb begin
    w_any  = |i_v;
    o_pick = LEAF_W'(rr_pick(MAX_PICK'(i_v), RRWAYS, int'(r_ptr)));
    // Reset gating holds every ready low while reset is asserted,
    // even though the stage register reads empty at that time.
    o_acc  = w_any && i_space && !reset;
    o_r    = '0;
    if (o_acc) begin
      o_r[o_pick] = 1'b1;
    end
  end

  // The way after the winner gets top priority next. RRWAYS is a power of 2,
  // so the add wraps on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_acc) begin
      r_ptr <= o_pick + 1'b1;
    end
  end

endmodule

// File: rtl/rr_merge_mc.sv
// Two-level merge of WAYS valid/ready streams into one output, tagged with the source id.
// Latency: 1 cycle from input handshake to o_v; each group sustains 1 beat/cycle.
// Backpressure: an unaccepted output beat is locked and kept stable; the group refills only when it pops.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   i_v/i_r    : per-stream valid/ready
//   i_d        : per-stream payload; stream k occupies [k*WIDTH +: WIDTH]
//   o_v/o_r    : output valid/ready
//   o_d        : payload of the granted beat
//   o_sel      : source stream id, formed as {group, leaf index}
//   o_burst    : beat count within the current group lock, including the present beat
module rr_merge_mc
  import rr_merge_pkg::*;
#(
  parameter  int WAYS    = 16,
  parameter  int WIDTH   = 1,
  parameter  int RRWAYS  = 4,
  parameter  int QUANTUM = 4,
  localparam int NMUX    = WAYS / RRWAYS,
  localparam int SEL_W   = width_of(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WAYS-1:0]       i_v,
  output logic [WAYS-1:0]       i_r,
  input  logic [WAYS*WIDTH-1:0] i_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [WIDTH-1:0]      o_d,
  output logic [SEL_W-1:0]      o_sel,
  output logic [7:0]            o_burst
);

  localparam int LEAF_W = $clog2(RRWAYS);
  localparam int GRP_W  = width_of(NMUX);
  localparam logic [7:0] Q8 = 8'(QUANTUM);

  typedef struct packed {
    logic [WIDTH-1:0]  payload;
    logic [LEAF_W-1:0] leaf_idx;
  } stage_t;

  // Stage registers, one per group.
  stage_t            r_stg [NMUX];
  logic [NMUX-1:0]   r_stg_vld;

  // Final arbiter state: locked group, beats taken from it, and the held grant.
  logic [GRP_W-1:0]  r_lock;
  logic [7:0]        r_cnt;
  logic              r_hold;
  logic [GRP_W-1:0]  r_hgrp;

  logic [NMUX-1:0]   w_space;
  logic [NMUX-1:0]   w_acc;
  logic [NMUX-1:0]   w_pop;
  logic [LEAF_W-1:0] w_pick [NMUX];
  logic [WIDTH-1:0]  w_in_dat [NMUX];
  logic [GRP_W-1:0]  w_grant;
  logic              w_fire;
  logic              w_keep;
  logic [7:0]        w_cnt_next;

  // ---------------------------------------------------------------------------
  // Leaf arbiters
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NMUX; g++) begin : g_leaf
    rr_arb_leaf #(
      .RRWAYS (RRWAYS)
    ) u_leaf (
      .clk     (clk),
      .reset   (reset),
      .i_v     (i_v[g*RRWAYS +: RRWAYS]),
      .i_space (w_space[g]),
      .o_r     (i_r[g*RRWAYS +: RRWAYS]),
      .o_acc   (w_acc[g]),
      .o_pick  (w_pick[g])
    );
  end

  // Steer the picked way's payload into its group's stage.
  // The constant indices keep the part-selects fixed after unrolling.
  always_comb begin
    for (int g = 0; g < NMUX; g++) begin
      w_in_dat[g] = '0;
      for (int j = 0; j < RRWAYS; j++) begin
        if (w_pick[g] == LEAF_W'(j)) begin
          w_in_dat[g] = i_d[(g*RRWAYS + j)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final quantum arbiter
  // ---------------------------------------------------------------------------
  always_comb begin
    o_v = |r_stg_vld;

    // A held beat keeps its group. Otherwise stay on the locked group while it
    // has data and quantum left. Otherwise search from the next group, leaving
    // the locked group for last.
    if (r_hold) begin
      w_grant = r_hgrp;
    end else if (r_stg_vld[r_lock] && (r_cnt < Q8)) begin
      w_grant = r_lock;
    end else begin
      w_grant = GRP_W'(rr_pick(MAX_PICK'(r_stg_vld), NMUX, int'(r_lock) + 1));
    end

    w_fire     = o_v && o_r;
    w_keep     = (w_grant == r_lock) && (r_cnt < Q8);
    w_cnt_next = w_keep ? (r_cnt + 8'd1) : 8'd1;
    o_burst    = o_v ? w_cnt_next : 8'd0;

    for (int g = 0; g < NMUX; g++) begin
      w_pop[g]   = w_fire && (w_grant == GRP_W'(g));
      // A stage that is popping on this edge can take a new beat on the same edge.
      w_space[g] = !r_stg_vld[g] || w_pop[g];
    end

    o_d = r_stg[w_grant].payload;
  end

  if (NMUX > 1) begin : g_sel_multi
    assign o_sel = {w_grant, r_stg[w_grant].leaf_idx};
  end else begin : g_sel_single
    assign o_sel = r_stg[0].leaf_idx;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_vld <= '0;
      for (int g = 0; g < NMUX; g++) begin
        r_stg[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NMUX; g++) begin
        if (w_acc[g]) begin
          r_stg_vld[g]      <= 1'b1;
          r_stg[g].payload  <= w_in_dat[g];
          r_stg[g].leaf_idx <= w_pick[g];
        end else if (w_pop[g]) begin
          r_stg_vld[g] <= 1'b0;
        end
      end
    end
  end

  // The lock starts on the last group with a spent quantum, so the first
  // search begins at group 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock <= GRP_W'(NMUX - 1);
      r_cnt  <= Q8;
      r_hold <= 1'b0;
      r_hgrp <= '0;
    end else if (w_fire) begin
      // When w_keep is set the grant is the locked group, so this keeps the lock.
      r_lock <= w_grant;
      r_cnt  <= w_cnt_next;
      r_hold <= 1'b0;
    end else if (o_v) begin
      r_hold <= 1'b1;
      r_hgrp <= w_grant;
    end
  end

endmodule

// File: tb/tb_rr_merge_mc.sv
module tb_rr_merge_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  i_v,  i_r;
  logic [15:0]  i_v1, i_r1;
  logic [127:0] i_d;
  logic         o_v,  o_r,  o_v1,  o_r1;
  logic [7:0]   o_d,  o_d1;
  logic [3:0]   o_sel, o_sel1;
  logic [7:0]   o_burst, o_burst1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] burst;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  rr_merge_mc #(.WAYS(16), .WIDTH(8), .RRWAYS(4), .QUANTUM(4)) u_dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_sel(o_sel), .o_burst(o_burst)
  );

  rr_merge_mc #(.WAYS(16), .WIDTH(8), .RRWAYS(4), .QUANTUM(1)) u_dut_q1 (
    .clk(clk), .reset(reset), .i_v(i_v1), .i_r(i_r1), .i_d(i_d),
    .o_v(o_v1), .o_r(o_r1), .o_d(o_d1), .o_sel(o_sel1), .o_burst(o_burst1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit which, input int sel, input int burst);
    exp_t e;
    e.sel   = 4'(sel);
    e.burst = 8'(burst);
    if (which) sb1.push_back(e);
    else       sb0.push_back(e);
  endtask

  // Each cycle: o_v must be high, and the beat that goes out on the next edge
  // must match the head of the scoreboard.
  task automatic drain(input bit which, input int n, input string tag);
    exp_t e;
    logic v, r;
    logic [3:0] s;
    logic [7:0] d, b;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      v = which ? o_v1 : o_v;
      r = which ? o_r1 : o_r;
      s = which ? o_sel1 : o_sel;
      d = which ? o_d1 : o_d;
      b = which ? o_burst1 : o_burst;
      chk($sformatf("%s_ov%0d", tag, c), 32'(v), 32'd1);
      if (v && r) begin
        if ((which ? sb1.size() : sb0.size()) == 0) begin
          checks++;
          errors++;
          $error("FAIL %s_sb_empty observed=beat expected=none", tag);
        end else begin
          e = which ? sb1.pop_front() : sb0.pop_front();
          chk($sformatf("%s_sel%0d", tag, c), 32'(s), 32'(e.sel));
          chk($sformatf("%s_dat%0d", tag, c), 32'(d), 32'(e.sel));
          chk($sformatf("%s_burst%0d", tag, c), 32'(b), 32'(e.burst));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_v   = '0;
    i_v1  = '0;
    o_r   = 1'b0;
    o_r1  = 1'b0;
    for (int k = 0; k < 16; k++) i_d[k*8 +: 8] = 8'(k);
    repeat (2) @(negedge clk);

    // Reset state, with requests already pending
    i_v = '1;
    #1;
    chk("rst_ov", 32'(o_v), 32'd0);
    chk("rst_ir", 32'(i_r), 32'd0);
    chk("rst_burst", 32'(o_burst), 32'd0);

    // Saturation: every stream valid, sink always ready
    @(negedge clk);
    o_r = 1'b1;
    for (int i = 0; i < 32; i++) push(1'b0, i % 16, (i % 4) + 1);
    reset = 1'b0;
    drain(1'b0, 32, "sat");
    chk("sat_sb_left", 32'(sb0.size()), 32'd0);

    // Asynchronous reset mid-traffic
    chk("midrst_pre_ov", 32'(o_v), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ov", 32'(o_v), 32'd0);
    chk("midrst_ir", 32'(i_r), 32'd0);
    chk("midrst_burst", 32'(o_burst), 32'd0);
    @(negedge clk);
    push(1'b0, 0, 1);
    push(1'b0, 1, 2);
    reset = 1'b0;
    drain(1'b0, 2, "postrst");

    // Quantum rotation between streams 0 and 5
    reset = 1'b1;
    i_v   = '0;
    @(negedge clk);
    i_v = 16'h0021;
    for (int i = 0; i < 9; i++) push(1'b0, ((i / 4) % 2 == 1) ? 5 : 0, (i % 4) + 1);
    reset = 1'b0;
    drain(1'b0, 9, "quant");

    // Early rotate: stream 1 stops after two beats
    reset = 1'b1;
    i_v   = '0;
    @(negedge clk);
    i_v = 16'h0202;
    push(1'b0, 1, 1);
    push(1'b0, 1, 2);
    reset = 1'b0;
    drain(1'b0, 2, "early_a");
    i_v[1] = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 9, (i % 4) + 1);
    drain(1'b0, 5, "early_b");

    // Backpressure hold: stream 13 waits while group 2 becomes valid
    reset = 1'b1;
    i_v   = '0;
    o_r   = 1'b0;
    @(negedge clk);
    i_v[13] = 1'b1;
    reset   = 1'b0;
    @(negedge clk);
    chk("hold_ov", 32'(o_v), 32'd1);
    chk("hold_sel_init", 32'(o_sel), 32'd13);
    i_v[8] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold_sel%0d", c), 32'(o_sel), 32'd13);
      chk($sformatf("hold_dat%0d", c), 32'(o_d), 32'd13);
      chk($sformatf("hold_ir%0d", c), 32'(i_r[13]), 32'd0);
    end
    o_r = 1'b1;
    #1;
    chk("hold_rel_sel", 32'(o_sel), 32'd13);
    chk("hold_rel_burst", 32'(o_burst), 32'd1);
    chk("hold_rel_ir", 32'(i_r[13]), 32'd1);
    push(1'b0, 13, 2);
    push(1'b0, 13, 3);
    push(1'b0, 13, 4);
    push(1'b0, 8, 1);
    drain(1'b0, 4, "hold_after");

    // QUANTUM=1 instance: per-beat rotation over groups 0, 1, 2
    reset = 1'b1;
    i_v   = '0;
    o_r   = 1'b0;
    @(negedge clk);
    i_v1 = 16'h0111;
    o_r1 = 1'b1;
    for (int i = 0; i < 6; i++) push(1'b1, (i % 3) * 4, 1);
    reset = 1'b0;
    drain(1'b1, 6, "q1");
    chk("q1_sb_left", 32'(sb1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
